// File: rtl/delay_block_reader.sv
// Read-side sequencer for the delay-block RAM ring: sweeps one block of read
// addresses and streams the returned words through a 2-entry skid FIFO.
module delay_block_reader #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 512,
    localparam int ADDR_W    = $clog2(BLOCK_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WIDTH-1:0]  ram_do,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_SIZE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              busy_r;
    logic              done_r;

    logic [1:0]        occ_r;
    logic              valid_r;
    logic [WIDTH-1:0]  data0_r;
    logic [WIDTH-1:0]  data1_r;
    logic              last0_r;
    logic              last1_r;

    logic              pop_s;
    logic [2:0]        credit_s;
    logic              issue_s;
    logic              last_addr_s;
    logic              finish_s;
    logic [1:0]        occ_next_s;

    // Credit check, FIFO occupancy update and end-of-block detection.
    always_comb begin
        pop_s       = valid_r & m_ready;
        credit_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        last_addr_s = (addr_r == LAST_ADDR);
        if (state_r == S_RUN) begin
            issue_s = (credit_s < 3'd2);
        end else begin
            issue_s = 1'b0;
        end
        // The last-tagged word is always the final one, so popping it empties the pipe.
        if (state_r == S_DRAIN) begin
            finish_s = pop_s & last0_r;
        end else begin
            finish_s = 1'b0;
        end
        case ({inflight_r, pop_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase
    end

    // Skid FIFO: entry 0 is the head; vacated entries are cleared so an empty FIFO shows zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
            data0_r <= DATA_ZERO;
            data1_r <= DATA_ZERO;
            last0_r <= 1'b0;
            last1_r <= 1'b0;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        data0_r <= ram_do;
                        last0_r <= inflight_last_r;
                    end else begin
                        data1_r <= ram_do;
                        last1_r <= inflight_last_r;
                    end
                end
                2'b01: begin
                    data0_r <= data1_r;
                    last0_r <= last1_r;
                    data1_r <= DATA_ZERO;
                    last1_r <= 1'b0;
                end
                2'b11: begin
                    if (occ_r == 2'd2) begin
                        data0_r <= data1_r;
                        last0_r <= last1_r;
                        data1_r <= ram_do;
                        last1_r <= inflight_last_r;
                    end else begin
                        data0_r <= ram_do;
                        last0_r <= inflight_last_r;
                    end
                end
                default: begin
                    data0_r <= data0_r;
                    last0_r <= last0_r;
                end
            endcase
            occ_r   <= occ_next_s;
            valid_r <= (occ_next_s != 2'd0);
        end
    end

    // Sequencer FSM: address sweep, in-flight tracking, busy and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= S_IDLE;
            addr_r          <= ADDR_ZERO;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s & last_addr_s;
            done_r          <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    addr_r <= ADDR_ZERO;
                    if (start) begin
                        state_r <= S_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (issue_s) begin
                        addr_r <= addr_r + ADDR_ONE;
                        if (last_addr_s) begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (finish_s) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        addr_r  <= ADDR_ZERO;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    addr_r  <= ADDR_ZERO;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign ram_addr = addr_r;
    assign m_valid  = valid_r;
    assign m_data   = data0_r;
    assign m_last   = last0_r;

endmodule

// File: tb/tb_delay_block_reader.sv
// Bench for delay_block_reader: a 512-word instance driven by randomized ready
// patterns against a word-queue model, plus a 4-word instance for the full-FIFO case.
module tb_delay_block_reader;

    localparam int BS  = 512;
    localparam int BS4 = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [8:0]  ram_addr;
    logic [15:0] ram_do;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;

    logic        start4;
    logic        busy4;
    logic        done4;
    logic [1:0]  ram_addr4;
    logic [15:0] ram_do4;
    logic        m_valid4;
    logic        m_ready4;
    logic [15:0] m_data4;
    logic        m_last4;

    logic [15:0] salt;

    delay_block_reader #(.WIDTH(16), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_do(ram_do), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    delay_block_reader #(.WIDTH(16), .BLOCK_SIZE(BS4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .ram_addr(ram_addr4), .ram_do(ram_do4), .m_valid(m_valid4),
        .m_ready(m_ready4), .m_data(m_data4), .m_last(m_last4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring read ports: one-cycle read latency, content is a function of the address.
    always @(posedge clk) ram_do  <= {7'd0, ram_addr} ^ salt;
    always @(posedge clk) ram_do4 <= {14'd0, ram_addr4} ^ 16'h3C3C;

    int n_checks = 0;
    int n_err    = 0;

    logic [16:0] exp_q[$];
    bit          busy_exp, done_exp, blk_end, prev_stall, prev_last;
    logic [15:0] prev_data;
    logic [8:0]  prev_addr;
    int          issued, popped, cyc_n, done_seen;
    int          start_cyc, first_valid_cyc, last_cyc, done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the 512-word instance: check, then drive ready/start for the next edge.
    task automatic cyc(input logic rdy, input logic st);
        bit          nxt_busy;
        bit          nxt_done;
        logic [16:0] e;
        @(negedge clk);
        cyc_n++;
        chk("busy", busy, busy_exp);
        chk("done", done, done_exp);
        if (done === 1'b1) begin
            done_seen++;
            done_cyc = cyc_n;
        end
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (ram_addr !== prev_addr) issued++;
        prev_addr = ram_addr;
        chk("outstanding_le2", (issued - popped) <= 2, 1);
        if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc_n;
        m_ready  = rdy;
        start    = st;
        nxt_busy = busy_exp;
        nxt_done = 1'b0;
        if (m_valid === 1'b1 && rdy) begin
            chk("extra_word", exp_q.size() == 0, 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word", {m_last, m_data}, e);
                popped++;
                if (e[16]) begin
                    nxt_done = 1'b1;
                    nxt_busy = 1'b0;
                    blk_end  = 1'b1;
                    last_cyc = cyc_n;
                end
            end
        end
        prev_stall = (m_valid === 1'b1) && !rdy;
        prev_data  = m_data;
        prev_last  = m_last;
        if (st && !busy_exp) begin
            nxt_busy        = 1'b1;
            start_cyc       = cyc_n;
            first_valid_cyc = -1;
            for (int k = 0; k < BS; k++) exp_q.push_back({k == BS - 1, 16'(k) ^ salt});
        end
        busy_exp = nxt_busy;
        done_exp = nxt_done;
    endtask

    // mode 0: always ready; 1: 1-0-0-1 pattern with a 10-cycle stall; 2: random ready.
    task automatic run_block(input int mode, input int restart_at, input int abort_at, output bit aborted);
        int   k, base, hold;
        bit   restarted, held;
        logic r, st;
        blk_end   = 1'b0;
        aborted   = 1'b0;
        restarted = 1'b0;
        held      = 1'b0;
        hold      = 0;
        salt      = (mode == 0) ? 16'hA5A5 : 16'($urandom);
        base      = popped;
        cyc(1'b1, 1'b1);
        k = 0;
        while (!blk_end && k < 4000) begin
            if (abort_at >= 0 && popped - base >= abort_at) begin
                aborted = 1'b1;
                break;
            end
            case (mode)
                0: r = 1'b1;
                1: begin
                    if (!held && popped - base >= 250) begin
                        hold = 10;
                        held = 1'b1;
                    end
                    if (hold > 0) begin
                        r = 1'b0;
                        hold--;
                    end else begin
                        r = (k % 4 == 0) || (k % 4 == 3);
                    end
                end
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            st = 1'b0;
            if (restart_at >= 0 && !restarted && popped - base >= restart_at) begin
                st        = 1'b1;
                restarted = 1'b1;
            end
            cyc(r, st);
            k++;
        end
        if (!aborted) chk("block_complete", blk_end, 1);
    endtask

    initial begin
        bit          ab;
        int          d0, iss4, w;
        logic [1:0]  prev4;
        rst = 1'b0; start = 1'b0; m_ready = 1'b0;
        start4 = 1'b0; m_ready4 = 1'b0; salt = 16'h0000;
        busy_exp = 1'b0; done_exp = 1'b0; prev_stall = 1'b0; prev_last = 1'b0;
        prev_data = 16'h0000; prev_addr = 9'd0;
        issued = 0; popped = 0; cyc_n = 0; done_seen = 0;
        start_cyc = 0; first_valid_cyc = -1; last_cyc = 0; done_cyc = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_addr", ram_addr, 0);
        rst = 1'b1;

        // Full-rate block with latency checks.
        run_block(0, -1, -1, ab);
        cyc(1'b1, 1'b0);
        chk("first_valid_lat", first_valid_cyc - start_cyc, 3);
        chk("last_word_lat", last_cyc - start_cyc, 514);
        chk("done_lat", done_cyc - start_cyc, 515);
        chk("t1_done_count", done_seen, 1);
        chk("t1_queue_empty", exp_q.size(), 0);
        repeat (3) cyc(1'b1, 1'b0);

        // Back-pressure pattern with a long stall.
        run_block(1, -1, -1, ab);
        cyc(1'b1, 1'b0);
        chk("t2_queue_empty", exp_q.size(), 0);

        // start re-asserted mid-block is ignored.
        d0 = done_seen;
        run_block(2, 100, -1, ab);
        repeat (4) cyc(1'b1, 1'b0);
        chk("t3_single_done", done_seen - d0, 1);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Asynchronous reset mid-block.
        run_block(2, -1, 200, ab);
        chk("t4_aborted", ab, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_valid", m_valid, 0);
        chk("arst_last", m_last, 0);
        chk("arst_data", m_data, 0);
        chk("arst_addr", ram_addr, 0);
        exp_q.delete();
        busy_exp = 1'b0; done_exp = 1'b0; prev_stall = 1'b0;
        issued = 0; popped = 0; prev_addr = 9'd0;
        start = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        d0 = done_seen;
        repeat (5) cyc(1'b1, 1'b0);
        chk("t4_no_done", done_seen - d0, 0);
        run_block(2, -1, -1, ab);
        cyc(1'b1, 1'b0);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Back-to-back blocks: second start lands in the done cycle.
        run_block(2, -1, -1, ab);
        run_block(1, -1, -1, ab);
        cyc(1'b1, 1'b0);
        chk("t6_queue_empty", exp_q.size(), 0);

        // BLOCK_SIZE=4: fill the FIFO before any pop.
        @(negedge clk);
        start4 = 1'b1;
        m_ready4 = 1'b0;
        prev4 = ram_addr4;
        iss4 = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (ram_addr4 !== prev4) iss4++;
            prev4 = ram_addr4;
        end
        chk("bs4_issued_before_pop", iss4, 2);
        chk("bs4_valid_full", m_valid4, 1);
        chk("bs4_busy", busy4, 1);
        m_ready4 = 1'b1;
        w = 0;
        for (int t = 0; t < 20 && w < BS4; t++) begin
            if (m_valid4 === 1'b1) begin
                chk("bs4_word", {m_last4, m_data4}, {w == BS4 - 1, 16'(w) ^ 16'h3C3C});
                w++;
            end
            @(negedge clk);
        end
        chk("bs4_word_count", w, BS4);
        chk("bs4_done", done4, 1);
        chk("bs4_idle", busy4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
